// File: rtl/xbar_target_pkg.sv
// rtl/xbar_target_pkg.sv - shared types and helpers for the crossbar slave target
package xbar_target_pkg;

    // Default widths; the tracker entry layout is built from these.
    localparam int XT_ADDR_WIDTH    = 32;
    localparam int XT_DATA_WIDTH    = 32;
    localparam int XT_BE_WIDTH      = XT_DATA_WIDTH / 8;
    localparam int XT_ID_WIDTH      = 9;
    localparam int XT_AUX_WIDTH     = 8;
    localparam int XT_N_OUTSTANDING = 4;

    // One in-flight request: routing tags, error flag, load/store, completion state, read data.
    typedef struct packed {
        logic [XT_ID_WIDTH-1:0]   id;
        logic [XT_AUX_WIDTH-1:0]  aux;
        logic                     err;
        logic                     wen;
        logic                     done;
        logic [XT_DATA_WIDTH-1:0] rdata;
    } xt_entry_t;

    // Pointer width for a power-of-two tracker depth (at least 1 bit).
    function automatic int xt_ptr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/xbar_slave_target_if.sv
// rtl/xbar_slave_target_if.sv - crossbar-side and memory-side signal bundle of the slave target
interface xbar_slave_target_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 9,
    parameter int AUX_WIDTH  = 8
);
    logic                  data_req_i;
    logic [ADDR_WIDTH-1:0] data_add_i;
    logic                  data_wen_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic [BE_WIDTH-1:0]   data_be_i;
    logic [ID_WIDTH-1:0]   data_ID_i;
    logic [AUX_WIDTH-1:0]  data_aux_i;
    logic                  data_gnt_o;
    logic                  data_r_valid_o;
    logic [DATA_WIDTH-1:0] data_r_rdata_o;
    logic [ID_WIDTH-1:0]   data_r_ID_o;
    logic                  data_r_opc_o;
    logic [AUX_WIDTH-1:0]  data_r_aux_o;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_add_o;
    logic                  mem_wen_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic                  mem_gnt_i;
    logic                  mem_r_valid_i;
    logic [DATA_WIDTH-1:0] mem_r_rdata_i;

    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i,
        output data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_ID_o, data_r_opc_o, data_r_aux_o,
        output mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
        input  mem_gnt_i, mem_r_valid_i, mem_r_rdata_i
    );

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i,
        input  data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_ID_o, data_r_opc_o, data_r_aux_o,
        input  mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
        output mem_gnt_i, mem_r_valid_i, mem_r_rdata_i
    );

endinterface

// File: rtl/xbar_resp_rob.sv
// rtl/xbar_resp_rob.sv - in-order response tracker with out-of-band completion of memory entries
module xbar_resp_rob
    import xbar_target_pkg::*;
#(
    parameter int N_OUTSTANDING = XT_N_OUTSTANDING
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  xt_entry_t                push_entry,
    input  logic                     cmp_valid,
    input  logic [XT_DATA_WIDTH-1:0] cmp_rdata,
    output logic                     pop,
    output logic [XT_ID_WIDTH-1:0]   head_id,
    output logic [XT_AUX_WIDTH-1:0]  head_aux,
    output logic                     head_err,
    output logic [XT_DATA_WIDTH-1:0] head_rdata,
    output logic                     full
);

    localparam int PTR_W = xt_ptr_width(N_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    xt_entry_t                entries [N_OUTSTANDING];
    logic [N_OUTSTANDING-1:0] valid;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         cmp_ptr;
    logic [CNT_W-1:0]         count_q;
    logic                     empty;
    logic                     cmp_hit;
    logic [PTR_W-1:0]         cmp_idx;
    logic [PTR_W-1:0]         scan_slot;

    assign full  = (count_q == CNT_W'(N_OUTSTANDING));
    assign empty = (count_q == '0);
    assign pop   = !empty && entries[rd_ptr].done;

    assign head_id    = entries[rd_ptr].id;
    assign head_aux   = entries[rd_ptr].aux;
    assign head_err   = entries[rd_ptr].err;
    assign head_rdata = entries[rd_ptr].rdata;

    // Find the oldest live entry still waiting on memory, starting at cmp_ptr; error
    // entries are already done so the scan steps over them. Entries behind cmp_ptr
    // are all done, so a wrapped scan can never pick a younger entry first.
    always_comb begin
        cmp_hit   = 1'b0;
        cmp_idx   = cmp_ptr;
        scan_slot = cmp_ptr;
        for (int k = N_OUTSTANDING - 1; k >= 0; k--) begin
            scan_slot = cmp_ptr + PTR_W'(k);
            if (valid[scan_slot] && !entries[scan_slot].done) begin
                cmp_hit = 1'b1;
                cmp_idx = scan_slot;
            end
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cmp_ptr <= '0;
            count_q <= '0;
            valid   <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Keep cmp_ptr from falling behind the head when an error entry pops under it.
            if (cmp_valid && cmp_hit) begin
                cmp_ptr <= cmp_idx + 1'b1;
            end else if (pop && (cmp_ptr == rd_ptr)) begin
                cmp_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry payload: written on push, completed by memory responses (loads keep the data).
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= push_entry;
        end
        if (cmp_valid && cmp_hit) begin
            entries[cmp_idx].done <= 1'b1;
            if (entries[cmp_idx].wen) begin
                entries[cmp_idx].rdata <= cmp_rdata;
            end
        end
    end

    // A memory response with nothing waiting for it is a protocol violation and is dropped.
    assert property (@(posedge clk) disable iff (!rst_n) cmp_valid |-> cmp_hit);

endmodule

// File: rtl/xbar_slave_target.sv
// rtl/xbar_slave_target.sv - crossbar output-port responder: range decode, grant, in-order responses
module xbar_slave_target
    import xbar_target_pkg::*;
#(
    parameter int ADDR_WIDTH    = XT_ADDR_WIDTH,
    parameter int DATA_WIDTH    = XT_DATA_WIDTH,
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = XT_ID_WIDTH,
    parameter int AUX_WIDTH     = XT_AUX_WIDTH,
    parameter int N_OUTSTANDING = XT_N_OUTSTANDING
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] START_ADDR,
    input  logic [ADDR_WIDTH-1:0] END_ADDR,
    xbar_slave_target_if.slave    bus
);

    logic                  in_range;
    logic                  full;
    logic                  push;
    logic                  pop;
    xt_entry_t             push_entry;
    logic [ID_WIDTH-1:0]   head_id;
    logic [AUX_WIDTH-1:0]  head_aux;
    logic                  head_err;
    logic [DATA_WIDTH-1:0] head_rdata;

    assign in_range = (bus.data_add_i >= START_ADDR) && (bus.data_add_i < END_ADDR);

    // Out-of-range requests are granted locally; in-range ones only when memory grants.
    assign bus.mem_req_o   = bus.data_req_i & in_range & ~full;
    assign bus.data_gnt_o  = bus.data_req_i & ~full & (in_range ? bus.mem_gnt_i : 1'b1);
    assign bus.mem_add_o   = bus.data_add_i - START_ADDR;
    assign bus.mem_wen_o   = bus.data_wen_i;
    assign bus.mem_wdata_o = DATA_WIDTH'(bus.data_wdata_i);
    assign bus.mem_be_o    = BE_WIDTH'(bus.data_be_i);
    assign push            = bus.data_gnt_o;

    // Build the tracker entry; error entries are born complete with zero data.
    always_comb begin
        push_entry      = '0;
        push_entry.id   = bus.data_ID_i;
        push_entry.aux  = bus.data_aux_i;
        push_entry.err  = ~in_range;
        push_entry.wen  = bus.data_wen_i;
        push_entry.done = ~in_range;
    end

    xbar_resp_rob #(
        .N_OUTSTANDING (N_OUTSTANDING)
    ) u_rob (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .cmp_valid  (bus.mem_r_valid_i),
        .cmp_rdata  (bus.mem_r_rdata_i),
        .pop        (pop),
        .head_id    (head_id),
        .head_aux   (head_aux),
        .head_err   (head_err),
        .head_rdata (head_rdata),
        .full       (full)
    );

    // Register the popped head as a one-cycle response; fields hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_r_valid_o <= 1'b0;
            bus.data_r_rdata_o <= '0;
            bus.data_r_ID_o    <= '0;
            bus.data_r_opc_o   <= 1'b0;
            bus.data_r_aux_o   <= '0;
        end else begin
            bus.data_r_valid_o <= pop;
            if (pop) begin
                bus.data_r_rdata_o <= head_rdata;
                bus.data_r_ID_o    <= head_id;
                bus.data_r_opc_o   <= head_err;
                bus.data_r_aux_o   <= head_aux;
            end
        end
    end

endmodule

// File: tb/tb_xbar_slave_target.sv
// tb/tb_xbar_slave_target.sv - self-checking bench for xbar_slave_target
module tb_xbar_slave_target;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] start_addr;
    logic [31:0] end_addr;

    xbar_slave_target_if bus ();

    xbar_slave_target dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .START_ADDR (start_addr),
        .END_ADDR   (end_addr),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  id;
        logic [7:0]  aux;
        logic        opc;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] rdata;
    } mem_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [8:0]  id;
        logic [7:0]  aux;
        logic        exp_mreq;
        logic [31:0] exp_add;
    } vec_t;

    exp_t sb[$];
    mem_t mq[$];
    int   resp_cyc_q[$];
    vec_t vecs[6];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         mem_lat = 1;
    logic       mem_hold = 1'b0;
    int         resp_cnt = 0;
    int         last_resp_cyc = 0;
    logic [8:0] last_resp_id = '0;
    int         mem_rv_cyc = 0;
    int         gnt_cyc = 0;
    logic       last_gnt = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [31:0] a, input logic w, input logic [8:0] id, input logic [7:0] aux);
        bus.data_req_i   = 1'b1;
        bus.data_add_i   = a;
        bus.data_wen_i   = w;
        bus.data_wdata_i = $urandom;
        bus.data_be_i    = 4'hF;
        bus.data_ID_i    = id;
        bus.data_aux_i   = aux;
    endtask

    task automatic idle();
        bus.data_req_i = 1'b0;
    endtask

    // One clock: check/record this cycle's handshakes, advance, score responses, drive memory.
    task automatic tick();
        exp_t        e;
        mem_t        m;
        logic        in_r;
        logic        exp_gnt;
        logic        exp_mreq;
        logic [31:0] d;
        #1;
        in_r     = (bus.data_add_i >= start_addr) && (bus.data_add_i < end_addr);
        exp_mreq = bus.data_req_i && in_r && (sb.size() < DEPTH);
        exp_gnt  = bus.data_req_i && (sb.size() < DEPTH) && (in_r ? bus.mem_gnt_i : 1'b1);
        last_gnt = bus.data_gnt_o;
        if (rst_n && bus.data_req_i) begin
            check("gnt", bus.data_gnt_o, exp_gnt);
            check("mem_req", bus.mem_req_o, exp_mreq);
            if (exp_mreq) check("mem_add", bus.mem_add_o, bus.data_add_i - start_addr);
        end
        d = $urandom;
        if (rst_n && exp_mreq && bus.mem_gnt_i) begin
            m.due   = cyc + mem_lat;
            m.rdata = d;
            mq.push_back(m);
        end
        if (rst_n && exp_gnt) begin
            e.id    = bus.data_ID_i;
            e.aux   = bus.data_aux_i;
            e.opc   = !in_r;
            e.rdata = (in_r && bus.data_wen_i) ? d : 32'h0;
            sb.push_back(e);
            gnt_cyc = cyc;
        end
        if (bus.mem_r_valid_i && mq.size() > 0) mq.delete(0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.data_r_valid_o) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            last_resp_id  = bus.data_r_ID_o;
            resp_cyc_q.push_back(cyc);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got response id 0x%0h, required none", bus.data_r_ID_o);
            end else begin
                e = sb.pop_front();
                check("r_id", bus.data_r_ID_o, e.id);
                check("r_aux", bus.data_r_aux_o, e.aux);
                check("r_opc", bus.data_r_opc_o, e.opc);
                check("r_rdata", bus.data_r_rdata_o, e.rdata);
            end
        end
        if (!mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.mem_r_valid_i = 1'b1;
            bus.mem_r_rdata_i = mq[0].rdata;
            mem_rv_cyc        = cyc;
        end else begin
            bus.mem_r_valid_i = 1'b0;
            bus.mem_r_rdata_i = $urandom;
        end
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        idle();
        while (sb.size() != 0 && b > 0) begin
            tick();
            b--;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d responses pending, required 0", sb.size());
            sb.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int r0;
        int gA;
        int ngnt;
        int b;

        vecs[0] = '{32'h0000_0FFF, 1'b1, 9'h001, 8'h11, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_1000, 1'b1, 9'h002, 8'h22, 1'b1, 32'h0};
        vecs[2] = '{32'h0000_1FFF, 1'b0, 9'h004, 8'h33, 1'b1, 32'h0000_0FFF};
        vecs[3] = '{32'h0000_2000, 1'b1, 9'h008, 8'h44, 1'b0, 32'h0};
        vecs[4] = '{32'hFFFF_FFFF, 1'b0, 9'h010, 8'h55, 1'b0, 32'h0};
        vecs[5] = '{32'h0000_1800, 1'b1, 9'h020, 8'h66, 1'b1, 32'h0000_0800};

        rst_n = 1'b0;
        start_addr = 32'h1000;
        end_addr   = 32'h2000;
        bus.data_req_i = 1'b0;
        bus.data_add_i = '0;
        bus.data_wen_i = 1'b0;
        bus.data_wdata_i = '0;
        bus.data_be_i = '0;
        bus.data_ID_i = '0;
        bus.data_aux_i = '0;
        bus.mem_gnt_i = 1'b1;
        bus.mem_r_valid_i = 1'b0;
        bus.mem_r_rdata_i = '0;

        @(negedge clk);
        tick();
        tick();
        check("reset_r_valid", bus.data_r_valid_o, 1'b0);
        check("reset_r_opc", bus.data_r_opc_o, 1'b0);
        check("reset_r_rdata", bus.data_r_rdata_o, 32'h0);
        check("reset_r_id", bus.data_r_ID_o, 9'h0);
        check("reset_r_aux", bus.data_r_aux_o, 8'h0);
        rst_n = 1'b1;
        tick();

        // Single load: offset address in the grant cycle, response two cycles after memory.
        r0 = resp_cnt;
        drive_req(32'h1004, 1'b1, 9'h004, 8'h5A);
        #1;
        check("load_mem_add", bus.mem_add_o, 32'h0000_0004);
        tick();
        drain(20);
        check("load_resp_count", resp_cnt - r0, 1);
        check("load_latency", last_resp_cyc - mem_rv_cyc, 2);

        // Out-of-range store answered locally two cycles after grant.
        drive_req(32'h3000, 1'b0, 9'h100, 8'h01);
        #1;
        check("err_gnt", bus.data_gnt_o, 1'b1);
        check("err_mem_req", bus.mem_req_o, 1'b0);
        tick();
        drain(20);
        check("err_latency", last_resp_cyc - gnt_cyc, 2);

        // Range boundaries from the vector table.
        for (int i = 0; i < 6; i++) begin
            drive_req(vecs[i].addr, vecs[i].wen, vecs[i].id, vecs[i].aux);
            #1;
            check("vec_gnt", bus.data_gnt_o, 1'b1);
            check("vec_mem_req", bus.mem_req_o, vecs[i].exp_mreq);
            if (vecs[i].exp_mreq) begin
                check("vec_mem_add", bus.mem_add_o, vecs[i].exp_add);
                check("vec_mem_wdata", bus.mem_wdata_o, bus.data_wdata_i);
                check("vec_mem_wen", bus.mem_wen_o, vecs[i].wen);
            end
            tick();
            drain(20);
        end

        // Slow load, error, fast load: responses stay in grant order.
        r0 = resp_cnt;
        mem_lat = 5;
        drive_req(32'h1100, 1'b1, 9'h001, 8'hA1);
        tick();
        gA = gnt_cyc;
        mem_lat = 1;
        drive_req(32'h2400, 1'b0, 9'h002, 8'hB2);
        tick();
        drive_req(32'h1200, 1'b1, 9'h008, 8'hC3);
        tick();
        drain(40);
        check("interleave_count", resp_cnt - r0, 3);
        check("interleave_c_cycle", last_resp_cyc - gA, 9);

        // Memory refuses grant: nothing accepted.
        bus.mem_gnt_i = 1'b0;
        drive_req(32'h1300, 1'b1, 9'h010, 8'h01);
        #1;
        check("nognt_mem_req", bus.mem_req_o, 1'b1);
        check("nognt_gnt", bus.data_gnt_o, 1'b0);
        tick();
        tick();
        tick();

        // Memory grants but stalls responses: tracker fills at four.
        bus.mem_gnt_i = 1'b1;
        mem_hold = 1'b1;
        ngnt = 0;
        for (int i = 0; i < 7; i++) begin
            drive_req(32'h1300 + 32'(i * 4), 1'b1, 9'(1 << (i % 9)), 8'(i));
            tick();
            if (last_gnt) ngnt++;
        end
        check("full_grants", ngnt, 4);
        r0 = resp_cnt;
        mem_hold = 1'b0;
        b = 30;
        #1;
        while (!bus.data_gnt_o && b > 0) begin
            tick();
            #1;
            b--;
        end
        check("resume_after_pop", (b > 0) && (cyc == last_resp_cyc) && (resp_cnt - r0 == 1), 1'b1);
        tick();
        drain(40);

        // Back-to-back traffic: one response per cycle.
        r0 = resp_cnt;
        resp_cyc_q.delete();
        for (int i = 0; i < 16; i++) begin
            drive_req(32'h1000 + 32'(i * 4), 1'(i % 3 != 0), 9'(1 << (i % 9)), 8'(8'h80 + i));
            tick();
        end
        drain(40);
        check("b2b_count", resp_cnt - r0, 16);
        if (resp_cyc_q.size() == 16) check("b2b_span", resp_cyc_q[15] - resp_cyc_q[0], 15);
        else check("b2b_span_size", resp_cyc_q.size(), 16);

        // Empty range: every request errors.
        end_addr = start_addr;
        r0 = resp_cnt;
        drive_req(32'h1000, 1'b1, 9'h080, 8'h77);
        #1;
        check("empty_range_mem_req", bus.mem_req_o, 1'b0);
        tick();
        drain(20);
        check("empty_range_count", resp_cnt - r0, 1);
        end_addr = 32'h2000;

        // Reset with three outstanding entries.
        mem_hold = 1'b1;
        drive_req(32'h1040, 1'b1, 9'h040, 8'h01);
        tick();
        drive_req(32'h1044, 1'b1, 9'h080, 8'h02);
        tick();
        drive_req(32'h1048, 1'b1, 9'h100, 8'h03);
        tick();
        idle();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_r_valid", bus.data_r_valid_o, 1'b0);
        check("rst_r_id", bus.data_r_ID_o, 9'h0);
        check("rst_r_aux", bus.data_r_aux_o, 8'h0);
        check("rst_r_rdata", bus.data_r_rdata_o, 32'h0);
        sb.delete();
        mq.delete();
        mem_hold = 1'b0;
        bus.mem_r_valid_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        r0 = resp_cnt;
        drive_req(32'h1010, 1'b1, 9'h020, 8'h9C);
        tick();
        drain(20);
        tick();
        tick();
        check("post_reset_count", resp_cnt - r0, 1);
        check("post_reset_id", last_resp_id, 9'h020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
